// File: rtl/tetris_game_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// tetris_game_sequencer: turns frame sync and buttons into one-at-a-time board commands.
// Revision 1.0 - initial release
module tetris_game_sequencer #(
  parameter int GRAVITY_INIT    = 8,
  parameter int GRAVITY_MIN     = 1,
  parameter int LINES_PER_LEVEL = 10
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       vsync,
  input  logic [4:0] operation,
  output logic       cmd_valid,
  output logic [2:0] cmd_op,
  output logic [2:0] cmd_piece,
  input  logic       cmd_ready,
  input  logic       rsp_ok,
  input  logic [2:0] rsp_rows,
  output logic [7:0] score,
  output logic [7:0] lines,
  output logic [3:0] level,
  output logic       playing,
  output logic       gameover
);

  localparam logic [2:0] c_OP_SPAWN  = 3'd0;
  localparam logic [2:0] c_OP_DOWN   = 3'd1;
  localparam logic [2:0] c_OP_LEFT   = 3'd2;
  localparam logic [2:0] c_OP_RIGHT  = 3'd3;
  localparam logic [2:0] c_OP_ROTATE = 3'd4;
  localparam logic [2:0] c_OP_CLEAR  = 3'd5;

  localparam int c_BTN_RIGHT  = 0;
  localparam int c_BTN_LEFT   = 1;
  localparam int c_BTN_DOWN   = 2;
  localparam int c_BTN_ROTATE = 3;
  localparam int c_BTN_START  = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SPAWN = 3'd1,
    S_PLAY  = 3'd2,
    S_ISSUE = 3'd3,
    S_CLEAR = 3'd4,
    S_SCORE = 3'd5,
    S_OVER  = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] vs_q;
  logic [2:0] lfsr_q;
  logic [4:0] pend_q, pend_d;
  logic [4:0] pend_clr;
  logic       grav_pend_q, grav_pend_d, grav_clr;
  logic [3:0] gcnt_q, gcnt_d;
  logic       cnt_clr;
  logic       grav_cmd_q, grav_cmd_d;
  logic [2:0] rows_q, rows_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic [2:0] cmd_op_q, cmd_op_d;
  logic [2:0] cmd_piece_q, cmd_piece_d;
  logic [7:0] score_q, score_d;
  logic [7:0] lines_q, lines_d;
  logic [3:0] level_q, level_d;
  logic       playing_q, playing_d;
  logic       gameover_q, gameover_d;

  logic       w_frame_tick;
  logic       w_ack;
  logic       w_grav_fire;
  logic [3:0] w_period;
  logic [3:0] w_pts;
  logic [2:0] w_rows_eff;
  logic [8:0] w_score_sum;
  logic [8:0] w_lines_sum;
  logic [7:0] w_score_next;
  logic [7:0] w_lines_next;
  logic [3:0] w_level_next;

  // vs_q[0]/[1] form the synchronizer, vs_q[2] holds the previous synced value.
  assign w_frame_tick = vs_q[1] & ~vs_q[2];
  assign w_ack        = cmd_valid_q & cmd_ready;

  always_comb begin
    int p;
    p = GRAVITY_INIT - int'(level_q);
    if (p < GRAVITY_MIN) p = GRAVITY_MIN;
    if (p < 1)           p = 1;
    w_period = 4'(p);
  end

  assign w_grav_fire = w_frame_tick && (gcnt_q >= (w_period - 4'd1));

  always_comb begin
    gcnt_d = gcnt_q;
    if (cnt_clr) begin
      gcnt_d = 4'd0;
    end else if (w_frame_tick) begin
      gcnt_d = w_grav_fire ? 4'd0 : (gcnt_q + 4'd1);
    end
    // A fresh gravity period beats a same-cycle service clear.
    grav_pend_d = (grav_pend_q & ~grav_clr) | w_grav_fire;
  end

  always_comb begin
    pend_d = (pend_q & ~pend_clr) | (w_frame_tick ? operation : 5'd0);
    if (pend_d[c_BTN_LEFT] && pend_d[c_BTN_RIGHT]) begin
      pend_d[c_BTN_LEFT]  = 1'b0;
      pend_d[c_BTN_RIGHT] = 1'b0;
    end
  end

  always_comb begin
    int lv;
    case (rows_q)
      3'd1:    w_pts = 4'd1;
      3'd2:    w_pts = 4'd3;
      3'd3:    w_pts = 4'd7;
      3'd4:    w_pts = 4'd10;
      default: w_pts = 4'd0;
    endcase
    w_rows_eff   = (rows_q <= 3'd4) ? rows_q : 3'd0;
    w_score_sum  = {1'b0, score_q} + {5'd0, w_pts};
    w_lines_sum  = {1'b0, lines_q} + {6'd0, w_rows_eff};
    w_score_next = w_score_sum[8] ? 8'hFF : w_score_sum[7:0];
    w_lines_next = w_lines_sum[8] ? 8'hFF : w_lines_sum[7:0];
    lv = int'(w_lines_next) / LINES_PER_LEVEL;
    if (lv > 15) lv = 15;
    w_level_next = 4'(lv);
  end

  always_comb begin
    state_d     = state_q;
    pend_clr    = 5'd0;
    grav_clr    = 1'b0;
    cnt_clr     = 1'b0;
    grav_cmd_d  = grav_cmd_q;
    rows_d      = rows_q;
    cmd_valid_d = cmd_valid_q;
    cmd_op_d    = cmd_op_q;
    cmd_piece_d = cmd_piece_q;
    score_d     = score_q;
    lines_d     = lines_q;
    level_d     = level_q;
    playing_d   = playing_q;
    gameover_d  = gameover_q;

    case (state_q)
      S_IDLE: begin
        // No piece on the board: movement and gravity requests are meaningless.
        pend_clr[3:0] = 4'hF;
        grav_clr      = 1'b1;
        if (pend_q[c_BTN_START]) begin
          pend_clr[c_BTN_START] = 1'b1;
          state_d               = S_SPAWN;
        end
      end

      S_SPAWN: begin
        pend_clr[c_BTN_START] = 1'b1;
        if (!cmd_valid_q) begin
          cmd_valid_d = 1'b1;
          cmd_op_d    = c_OP_SPAWN;
          cmd_piece_d = lfsr_q;
        end else if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          if (rsp_ok) begin
            playing_d = 1'b1;
            state_d   = S_PLAY;
          end else begin
            playing_d  = 1'b0;
            gameover_d = 1'b1;
            state_d    = S_OVER;
          end
        end
      end

      S_PLAY: begin
        pend_clr[c_BTN_START] = 1'b1;
        if (grav_pend_q) begin
          grav_clr    = 1'b1;
          grav_cmd_d  = 1'b1;
          cmd_valid_d = 1'b1;
          cmd_op_d    = c_OP_DOWN;
          state_d     = S_ISSUE;
        end else if (pend_q[c_BTN_DOWN]) begin
          pend_clr[c_BTN_DOWN] = 1'b1;
          grav_cmd_d           = 1'b0;
          cmd_valid_d          = 1'b1;
          cmd_op_d             = c_OP_DOWN;
          state_d              = S_ISSUE;
        end else if (pend_q[c_BTN_LEFT]) begin
          pend_clr[c_BTN_LEFT] = 1'b1;
          grav_cmd_d           = 1'b0;
          cmd_valid_d          = 1'b1;
          cmd_op_d             = c_OP_LEFT;
          state_d              = S_ISSUE;
        end else if (pend_q[c_BTN_RIGHT]) begin
          pend_clr[c_BTN_RIGHT] = 1'b1;
          grav_cmd_d            = 1'b0;
          cmd_valid_d           = 1'b1;
          cmd_op_d              = c_OP_RIGHT;
          state_d               = S_ISSUE;
        end else if (pend_q[c_BTN_ROTATE]) begin
          pend_clr[c_BTN_ROTATE] = 1'b1;
          grav_cmd_d             = 1'b0;
          cmd_valid_d            = 1'b1;
          cmd_op_d               = c_OP_ROTATE;
          state_d                = S_ISSUE;
        end
      end

      S_ISSUE: begin
        pend_clr[c_BTN_START] = 1'b1;
        if (w_ack) begin
          cmd_valid_d = 1'b0;
          // Only a blocked gravity step locks the piece; a blocked player DOWN is harmless.
          if (grav_cmd_q && !rsp_ok) begin
            playing_d = 1'b0;
            state_d   = S_CLEAR;
          end else begin
            state_d = S_PLAY;
          end
        end
      end

      S_CLEAR: begin
        pend_clr[c_BTN_START] = 1'b1;
        if (!cmd_valid_q) begin
          cmd_valid_d = 1'b1;
          cmd_op_d    = c_OP_CLEAR;
        end else if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          rows_d      = rsp_rows;
          state_d     = S_SCORE;
        end
      end

      S_SCORE: begin
        pend_clr[c_BTN_START] = 1'b1;
        score_d  = w_score_next;
        lines_d  = w_lines_next;
        level_d  = w_level_next;
        grav_clr = 1'b1;
        state_d  = S_SPAWN;
      end

      S_OVER: begin
        pend_clr[3:0] = 4'hF;
        grav_clr      = 1'b1;
        if (pend_q[c_BTN_START]) begin
          pend_clr[c_BTN_START] = 1'b1;
          score_d    = 8'd0;
          lines_d    = 8'd0;
          level_d    = 4'd0;
          cnt_clr    = 1'b1;
          gameover_d = 1'b0;
          state_d    = S_SPAWN;
        end
      end

      default: begin
        cmd_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      vs_q        <= 3'd0;
      lfsr_q      <= 3'b001;
      pend_q      <= 5'd0;
      grav_pend_q <= 1'b0;
      gcnt_q      <= 4'd0;
      grav_cmd_q  <= 1'b0;
      rows_q      <= 3'd0;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= 3'd0;
      cmd_piece_q <= 3'd0;
      score_q     <= 8'd0;
      lines_q     <= 8'd0;
      level_q     <= 4'd0;
      playing_q   <= 1'b0;
      gameover_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_q        <= {vs_q[1], vs_q[0], vsync};
      // x^3 + x^2 + 1: visits 1..7 and never reaches zero.
      lfsr_q      <= {lfsr_q[1:0], lfsr_q[2] ^ lfsr_q[1]};
      pend_q      <= pend_d;
      grav_pend_q <= grav_pend_d;
      gcnt_q      <= gcnt_d;
      grav_cmd_q  <= grav_cmd_d;
      rows_q      <= rows_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_op_q    <= cmd_op_d;
      cmd_piece_q <= cmd_piece_d;
      score_q     <= score_d;
      lines_q     <= lines_d;
      level_q     <= level_d;
      playing_q   <= playing_d;
      gameover_q  <= gameover_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_piece = cmd_piece_q;
  assign score     = score_q;
  assign lines     = lines_q;
  assign level     = level_q;
  assign playing   = playing_q;
  assign gameover  = gameover_q;

endmodule
`default_nettype wire

// File: tb/tb_tetris_game_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// tb_tetris_game_sequencer: directed self-checking bench for tetris_game_sequencer.
// Revision 1.0 - initial release
module tb_tetris_game_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       vsync;
  logic [4:0] operation;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [2:0] cmd_piece;
  logic       cmd_ready;
  logic       rsp_ok;
  logic [2:0] rsp_rows;
  logic [7:0] score;
  logic [7:0] lines;
  logic [3:0] level;
  logic       playing;
  logic       gameover;

  int n_vec = 0;
  int n_err = 0;

  logic       auto_ack = 1'b0;
  logic       ok_tbl [0:7];
  logic [2:0] rows_cfg = 3'd0;
  logic [2:0] log_op [$];
  logic [2:0] log_piece [$];

  int exp_cnt   = 0;
  int exp_lines = 0;
  int exp_level = 0;
  bit grav_fired;

  always #5 clock = ~clock;

  tetris_game_sequencer #(
    .GRAVITY_INIT   (8),
    .GRAVITY_MIN    (1),
    .LINES_PER_LEVEL(10)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .vsync    (vsync),
    .operation(operation),
    .cmd_valid(cmd_valid),
    .cmd_op   (cmd_op),
    .cmd_piece(cmd_piece),
    .cmd_ready(cmd_ready),
    .rsp_ok   (rsp_ok),
    .rsp_rows (rsp_rows),
    .score    (score),
    .lines    (lines),
    .level    (level),
    .playing  (playing),
    .gameover (gameover)
  );

  // Board engine stand-in: acknowledges each presented command and logs it.
  initial begin
    cmd_ready = 1'b0;
    rsp_ok    = 1'b0;
    rsp_rows  = 3'd0;
    forever begin
      @(negedge clock);
      cmd_ready = 1'b0;
      if (auto_ack && cmd_valid === 1'b1 && reset_n === 1'b1) begin
        cmd_ready = 1'b1;
        rsp_ok    = ok_tbl[cmd_op];
        rsp_rows  = rows_cfg;
        log_op.push_back(cmd_op);
        log_piece.push_back(cmd_piece);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  // One frame: vsync high 4 cycles with buttons held, then 16 quiet cycles.
  task automatic frame(input logic [4:0] ops);
    int p;
    p = 8 - exp_level;
    if (p < 1) p = 1;
    grav_fired = 1'b0;
    if (exp_cnt >= p - 1) begin
      exp_cnt    = 0;
      grav_fired = 1'b1;
    end else begin
      exp_cnt++;
    end
    @(negedge clock);
    operation = ops;
    vsync     = 1'b1;
    repeat (4) @(negedge clock);
    vsync     = 1'b0;
    operation = 5'd0;
    repeat (16) @(negedge clock);
  endtask

  task automatic run_to_gravity();
    for (int i = 0; i < 20; i++) begin
      frame(5'd0);
      if (grav_fired) break;
    end
  endtask

  task automatic do_lock(input logic [2:0] rows);
    rows_cfg = rows;
    run_to_gravity();
    exp_lines = exp_lines + ((rows <= 3'd4) ? int'(rows) : 0);
    if (exp_lines > 255) exp_lines = 255;
    exp_level = exp_lines / 10;
    if (exp_level > 15) exp_level = 15;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    vsync     = 1'b0;
    operation = 5'd0;
    for (int i = 0; i < 8; i++) ok_tbl[i] = 1'b1;
    repeat (3) @(negedge clock);
    n_vec++;
    if (cmd_valid !== 1'b0 || playing !== 1'b0 || gameover !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: got valid=%b playing=%b gameover=%b want 0 0 0", cmd_valid, playing, gameover);
    end
    n_vec++;
    if (score !== 8'd0 || lines !== 8'd0 || level !== 4'd0) begin
      n_err++;
      $display("FAIL reset_counters: got score=%0d lines=%0d level=%0d want 0 0 0", score, lines, level);
    end
    reset_n = 1'b1;
    exp_cnt = 0; exp_lines = 0; exp_level = 0;
    @(negedge clock);
  endtask

  task automatic test_start();
    auto_ack = 1'b1;
    log_op.delete(); log_piece.delete();
    frame(5'h10);
    n_vec++;
    if (log_op.size() != 1 || log_op[0] !== 3'd0) begin
      n_err++;
      $display("FAIL start_spawn: got %0d cmds first op=%0d want 1 cmd op=0", log_op.size(), log_op[0]);
    end
    n_vec++;
    if (log_piece[0] === 3'd0 || $isunknown(log_piece[0])) begin
      n_err++;
      $display("FAIL start_piece: got %0d want 1..7", log_piece[0]);
    end
    n_vec++;
    if (playing !== 1'b1 || score !== 8'd0 || level !== 4'd0) begin
      n_err++;
      $display("FAIL start_state: got playing=%b score=%0d level=%0d want 1 0 0", playing, score, level);
    end
  endtask

  task automatic test_gravity();
    log_op.delete();
    repeat (6) frame(5'd0);
    n_vec++;
    if (log_op.size() != 0) begin
      n_err++;
      $display("FAIL grav_early: got %0d cmds want 0", log_op.size());
    end
    frame(5'd0);
    n_vec++;
    if (log_op.size() != 1 || log_op[0] !== 3'd1) begin
      n_err++;
      $display("FAIL grav_first: got %0d cmds op=%0d want 1 cmd op=1", log_op.size(), log_op[0]);
    end
    repeat (7) frame(5'd0);
    n_vec++;
    if (log_op.size() != 1) begin
      n_err++;
      $display("FAIL grav_gap: got %0d cmds want 1", log_op.size());
    end
    frame(5'd0);
    n_vec++;
    if (log_op.size() != 2 || log_op[1] !== 3'd1) begin
      n_err++;
      $display("FAIL grav_second: got %0d cmds op=%0d want 2 cmds op=1", log_op.size(), log_op[1]);
    end
    auto_ack = 1'b0;
    repeat (8) frame(5'd0);
    n_vec++;
    if (cmd_valid !== 1'b1 || cmd_op !== 3'd1) begin
      n_err++;
      $display("FAIL grav_hold_start: got valid=%b op=%0d want 1 1", cmd_valid, cmd_op);
    end
    repeat (30) @(negedge clock);
    n_vec++;
    if (cmd_valid !== 1'b1 || cmd_op !== 3'd1) begin
      n_err++;
      $display("FAIL grav_hold_wait: got valid=%b op=%0d want 1 1", cmd_valid, cmd_op);
    end
    auto_ack = 1'b1;
    repeat (4) @(negedge clock);
    n_vec++;
    if (cmd_valid !== 1'b0 || log_op.size() != 3) begin
      n_err++;
      $display("FAIL grav_release: got valid=%b cmds=%0d want 0 3", cmd_valid, log_op.size());
    end
  endtask

  task automatic test_moves();
    log_op.delete();
    frame(5'h0A);
    n_vec++;
    if (log_op.size() != 2 || log_op[0] !== 3'd2 || log_op[1] !== 3'd4) begin
      n_err++;
      $display("FAIL left_rotate: got %0d cmds ops=%0d,%0d want 2 cmds ops=2,4", log_op.size(), log_op[0], log_op[1]);
    end
    log_op.delete();
    frame(5'h03);
    n_vec++;
    if (log_op.size() != 0) begin
      n_err++;
      $display("FAIL left_right_cancel: got %0d cmds want 0", log_op.size());
    end
    repeat (5) frame(5'd0);
    frame(5'h04);
    n_vec++;
    if (log_op.size() != 2 || log_op[0] !== 3'd1 || log_op[1] !== 3'd1) begin
      n_err++;
      $display("FAIL grav_plus_down: got %0d cmds ops=%0d,%0d want 2 cmds ops=1,1", log_op.size(), log_op[0], log_op[1]);
    end
  endtask

  task automatic test_lock();
    ok_tbl[1] = 1'b0;
    log_op.delete();
    frame(5'h04);
    n_vec++;
    if (log_op.size() != 1 || log_op[0] !== 3'd1 || playing !== 1'b1) begin
      n_err++;
      $display("FAIL player_down_blocked: got %0d cmds op=%0d playing=%b want 1 cmd op=1 playing=1", log_op.size(), log_op[0], playing);
    end
    log_op.delete(); log_piece.delete();
    do_lock(3'd4);
    n_vec++;
    if (log_op.size() != 3 || log_op[0] !== 3'd1 || log_op[1] !== 3'd5 || log_op[2] !== 3'd0) begin
      n_err++;
      $display("FAIL lock_sequence: got %0d cmds ops=%0d,%0d,%0d want 3 cmds ops=1,5,0", log_op.size(), log_op[0], log_op[1], log_op[2]);
    end
    n_vec++;
    if (log_piece[2] === 3'd0 || $isunknown(log_piece[2])) begin
      n_err++;
      $display("FAIL lock_piece: got %0d want 1..7", log_piece[2]);
    end
    n_vec++;
    if (score !== 8'd10 || lines !== 8'd4 || level !== 4'd0 || playing !== 1'b1) begin
      n_err++;
      $display("FAIL lock_score: got score=%0d lines=%0d level=%0d playing=%b want 10 4 0 1", score, lines, level, playing);
    end
  endtask

  task automatic test_level();
    do_lock(3'd4);
    do_lock(3'd2);
    n_vec++;
    if (score !== 8'd23 || lines !== 8'd10 || level !== 4'd1) begin
      n_err++;
      $display("FAIL level_up: got score=%0d lines=%0d level=%0d want 23 10 1", score, lines, level);
    end
    ok_tbl[1] = 1'b1;
    log_op.delete();
    repeat (6) frame(5'd0);
    n_vec++;
    if (log_op.size() != 0) begin
      n_err++;
      $display("FAIL period7_early: got %0d cmds want 0", log_op.size());
    end
    frame(5'd0);
    n_vec++;
    if (log_op.size() != 1 || log_op[0] !== 3'd1) begin
      n_err++;
      $display("FAIL period7_fire: got %0d cmds op=%0d want 1 cmd op=1", log_op.size(), log_op[0]);
    end
    ok_tbl[1] = 1'b0;
    for (int i = 0; i < 22; i++) do_lock(3'd4);
    n_vec++;
    if (score !== 8'd243 || lines !== 8'd98 || level !== 4'd9) begin
      n_err++;
      $display("FAIL many_clears: got score=%0d lines=%0d level=%0d want 243 98 9", score, lines, level);
    end
    do_lock(3'd3);
    n_vec++;
    if (score !== 8'd250 || lines !== 8'd101 || level !== 4'd10) begin
      n_err++;
      $display("FAIL score_250: got score=%0d lines=%0d level=%0d want 250 101 10", score, lines, level);
    end
    do_lock(3'd4);
    n_vec++;
    if (score !== 8'd255 || lines !== 8'd105 || level !== 4'd10) begin
      n_err++;
      $display("FAIL score_saturate: got score=%0d lines=%0d level=%0d want 255 105 10", score, lines, level);
    end
  endtask

  task automatic test_gameover();
    ok_tbl[0] = 1'b0;
    log_op.delete();
    do_lock(3'd0);
    n_vec++;
    if (log_op.size() != 3 || log_op[2] !== 3'd0 || gameover !== 1'b1 || playing !== 1'b0) begin
      n_err++;
      $display("FAIL spawn_blocked: got %0d cmds gameover=%b playing=%b want 3 cmds 1 0", log_op.size(), gameover, playing);
    end
    log_op.delete();
    repeat (20) frame(5'h05);
    n_vec++;
    if (log_op.size() != 0 || gameover !== 1'b1 || cmd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL over_silent: got %0d cmds gameover=%b valid=%b want 0 1 0", log_op.size(), gameover, cmd_valid);
    end
    ok_tbl[0] = 1'b1;
    ok_tbl[1] = 1'b1;
    frame(5'h10);
    exp_cnt = 0; exp_lines = 0; exp_level = 0;
    n_vec++;
    if (log_op.size() != 1 || log_op[0] !== 3'd0) begin
      n_err++;
      $display("FAIL restart_spawn: got %0d cmds op=%0d want 1 cmd op=0", log_op.size(), log_op[0]);
    end
    n_vec++;
    if (score !== 8'd0 || lines !== 8'd0 || level !== 4'd0 || gameover !== 1'b0 || playing !== 1'b1) begin
      n_err++;
      $display("FAIL restart_state: got score=%0d lines=%0d level=%0d gameover=%b playing=%b want 0 0 0 0 1",
               score, lines, level, gameover, playing);
    end
  endtask

  task automatic test_reset_mid();
    auto_ack = 1'b0;
    frame(5'h08);
    n_vec++;
    if (cmd_valid !== 1'b1 || cmd_op !== 3'd4) begin
      n_err++;
      $display("FAIL mid_pending: got valid=%b op=%0d want 1 4", cmd_valid, cmd_op);
    end
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if (cmd_valid !== 1'b0 || playing !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_async: got valid=%b playing=%b want 0 0", cmd_valid, playing);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    exp_cnt = 0; exp_lines = 0; exp_level = 0;
    auto_ack = 1'b1;
    log_op.delete();
    repeat (10) @(negedge clock);
    n_vec++;
    if (log_op.size() != 0) begin
      n_err++;
      $display("FAIL mid_reset_quiet: got %0d cmds want 0", log_op.size());
    end
    frame(5'h10);
    n_vec++;
    if (log_op.size() != 1 || log_op[0] !== 3'd0 || playing !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset_idle: got %0d cmds op=%0d playing=%b want 1 cmd op=0 playing=1", log_op.size(), log_op[0], playing);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_gravity();
    test_moves();
    test_lock();
    test_level();
    test_gameover();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tetris_game_sequencer.md
Name: tetris_game_sequencer

Overview:
- Central game controller for the Tetris board datapath.
- Converts frame sync and player buttons into a serialized stream of single board commands over a valid/ready handshake.
- Commands: spawn, move down/left/right, rotate, row clear.
- Owns gravity timing, piece selection, lock/clear/score sequencing, levels and game-over; the board engine executes one command at a time and reports the result.

Parameters:
GRAVITY_INIT, 8, frames per gravity step at level 0 (1..15)
GRAVITY_MIN, 1, lower bound on frames per gravity step
LINES_PER_LEVEL, 10, cleared lines per level increment

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
vsync  input  1  raw frame sync, asynchronous to clock
operation  input  5  buttons: bit0 RIGHT, bit1 LEFT, bit2 DOWN, bit3 ROTATE, bit4 START
cmd_valid  output  1  command presented to board engine
cmd_op  output  3  0 SPAWN, 1 DOWN, 2 LEFT, 3 RIGHT, 4 ROTATE, 5 CLEAR
cmd_piece  output  3  piece type for SPAWN (1..7, never 0/BLANK)
cmd_ready  input  1  one-cycle completion strobe from engine
rsp_ok  input  1  with cmd_ready: move/spawn succeeded (1) or blocked (0)
rsp_rows  input  3  with cmd_ready on CLEAR: rows deleted, 0..4
score  output  8  saturating score
lines  output  8  saturating cleared-line count
level  output  4  current level
playing  output  1  piece active
gameover  output  1  game lost

Behaviour:
- Reset (async, immediate): all outputs 0; cmd_valid drops at once; FSM IDLE; LFSR=3'b001; gravity counter 0; pending flags cleared.
- vsync passes through a 2-flop synchronizer; its rising edge yields frame_tick, one clock wide.
- On frame_tick, operation is latched into pending[4:0]; bits already pending stay set. LEFT&RIGHT both set → both discarded.
- Gravity counter increments on frame_tick. When it reaches period-1, grav_pend is set and the counter returns to 0.
- period = max(GRAVITY_INIT - level, GRAVITY_MIN); recomputed whenever level changes.
- Piece LFSR: x^3+x^2+1, advances every clock, sequence 1..7, never 0. Its value is captured into cmd_piece when SPAWN is issued.
- Handshake:
  - cmd_op/cmd_piece stay stable while cmd_valid=1; the sequencer waits indefinitely for cmd_ready.
  - rsp_* are sampled only in the cmd_ready cycle.
  - After cmd_ready, cmd_valid is 0 for at least one cycle.
  - cmd_ready while cmd_valid=0 is ignored.
- FSM states: IDLE, SPAWN, PLAY, ISSUE, CLEAR, SCORE, OVER.
  - IDLE: wait for pending START → clear START, go to SPAWN.
  - SPAWN: issue SPAWN. ok → PLAY, playing=1. !ok → OVER, gameover=1, playing=0.
  - PLAY: pick the next command by priority:
    - 1. grav_pend → DOWN (gravity).
    - 2. pending DOWN.
    - 3. pending LEFT / RIGHT.
    - 4. pending ROTATE.
    - Clear the chosen flag, go to ISSUE. START is ignored while playing.
  - ISSUE: wait for cmd_ready.
    - Gravity DOWN with !ok → CLEAR (piece locks), playing=0.
    - Any other result → PLAY. Player DOWN blocked does not lock.
  - CLEAR: issue CLEAR; on cmd_ready capture rsp_rows → SCORE.
  - SCORE, one cycle:
    - score += {0,1,3,7,10}[rows]; rows 5..7 treated as 0; saturate at 255.
    - lines += rows; saturate at 255.
    - level = min(lines / LINES_PER_LEVEL, 15).
    - Clear grav_pend → SPAWN.
  - OVER: no commands issued. Pending START → score/lines/level/counter cleared → SPAWN, gameover=0.
- Simultaneous frame_tick and flag clear in the same cycle: the newly latched bit wins (remains set).
- At most one gravity step is pending; extra periods elapsing before service are dropped.

Test Plan:
- Reset, START held across one vsync → SPAWN with cmd_piece in 1..7; ack rsp_ok=1 → playing=1, score=0, level=0.
- GRAVITY_INIT=8, no buttons, always ack ok → exactly one DOWN every 8 vsync edges; cmd_valid stays high until cmd_ready.
- Same frame LEFT+ROTATE → LEFT then ROTATE commands in order; LEFT+RIGHT in one frame → no command; gravity and DOWN in same frame → two DOWNs, gravity first.
- Gravity DOWN rsp_ok=0 → CLEAR issued; rsp_rows=4 → score 10, lines 4, then SPAWN; player DOWN rsp_ok=0 → no CLEAR, stays PLAY.
- Clears bring lines to 10 → level=1, gravity period 7 frames; score at 250 plus 4-row clear → 255 (saturated).
- SPAWN rsp_ok=0 → gameover=1, no commands for 20 frames; START → score 0, lines 0, SPAWN issued; reset_n asserted mid-handshake → cmd_valid 0 immediately, FSM IDLE.
